// File: rtl/seq1001_pkg.sv
// seq1001_pkg: shared constants for the 1001 sync-framed serial link.
// State encoding, sync pattern and a helper that picks one sync bit.
package seq1001_pkg;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SYNC   = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STUFF  = 3'd3;
   localparam logic [2:0] PARITY = 3'd4;

   localparam logic [3:0] SYNC_PATTERN = 4'b1001;
   localparam int         SYNC_LEN     = 4;

   // Sync bit number idx in transmission order (0 = first bit on the line).
   function automatic logic sync_bit(input logic [1:0] idx);
      logic [3:0] pat;
      pat = SYNC_PATTERN;
      return pat[2'd3 - idx];
   endfunction

endpackage

// File: rtl/seq1001_tx_if.sv
// seq1001_tx_if: payload valid/ready handshake into the transmitter.
interface seq1001_tx_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq1001_stuffer.sv
// seq1001_stuffer: counts consecutive emitted zeros and requests a stuffed 0
// once two in a row have gone out, so 1001 can never be formed by payload.
module seq1001_stuffer (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic bit_en,
   input  logic bit_val,
   output logic stuff_req
);
   logic [1:0] zero_run;

   // Run-length of zeros since the last emitted 1 or stuffed bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         zero_run <= 2'd0;
      else if (clr)
         zero_run <= 2'd0;
      else if (bit_en)
         zero_run <= bit_val ? 2'd0 : zero_run + 2'd1;
   end

   assign stuff_req = (zero_run == 2'd2);

endmodule

// File: rtl/seq1001_tx.sv
// seq1001_tx: serial frame transmitter. Frame = sync 1001, then payload
// MSB-first with a 0 stuffed after every pair of payload zeros.
// Optional even-parity bit after the payload: define SEQ1001_TX_PARITY_EN.
module seq1001_tx
   import seq1001_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  logic        clk,
   input  logic        rst_n,
   seq1001_tx_if.slave bus,
   output logic        sdo,
   output logic        busy,
   output logic        frame_done
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [2:0]        state;
   logic [2:0]        state_nx;
   logic              sdo_nx;
   logic [1:0]        sync_idx;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic              accept;
   logic              take_data;
   logic              bit_en;
   logic              bit_val;
   logic              run_clr;
   logic              stuff_req;
`ifdef SEQ1001_TX_PARITY_EN
   logic              par_bit;
   logic              par_sent;
`endif

   assign accept = bus.in_valid && bus.in_ready;

   seq1001_stuffer u_stuffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (run_clr),
      .bit_en    (bit_en),
      .bit_val   (bit_val),
      .stuff_req (stuff_req)
   );

   // Next state and the bit that goes on the line during the next cycle.
   always_comb begin
      state_nx  = state;
      sdo_nx    = 1'b1;
      take_data = 1'b0;
      bit_en    = 1'b0;
      bit_val   = 1'b0;
      run_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = SYNC;
               sdo_nx   = sync_bit(2'd0);
               run_clr  = 1'b1;
            end
         end
         SYNC: begin
            if (sync_idx != 2'(SYNC_LEN - 1)) begin
               sdo_nx = sync_bit(sync_idx + 2'd1);
            end else begin
               state_nx  = DATA;
               sdo_nx    = shreg[DATA_W-1];
               take_data = 1'b1;
               bit_en    = 1'b1;
               bit_val   = shreg[DATA_W-1];
            end
         end
         DATA, STUFF, PARITY: begin
            if (state != STUFF && stuff_req) begin
               state_nx = STUFF;
               sdo_nx   = 1'b0;
               run_clr  = 1'b1;
            end else if (bit_cnt != CNT_W'(DATA_W)) begin
               state_nx  = DATA;
               sdo_nx    = shreg[DATA_W-1];
               take_data = 1'b1;
               bit_en    = 1'b1;
               bit_val   = shreg[DATA_W-1];
            end
`ifdef SEQ1001_TX_PARITY_EN
            else if (!par_sent) begin
               state_nx = PARITY;
               sdo_nx   = par_bit;
               bit_en   = 1'b1;
               bit_val  = par_bit;
            end
`endif
            else begin
               state_nx = IDLE;
               sdo_nx   = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            sdo_nx   = 1'b1;
         end
      endcase
   end

   // Control state and registered outputs; reset aborts any frame at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         sdo          <= 1'b1;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         bus.in_ready <= 1'b1;
         sync_idx     <= 2'd0;
         bit_cnt      <= '0;
      end else begin
         state        <= state_nx;
         sdo          <= sdo_nx;
         busy         <= (state_nx != IDLE);
         frame_done   <= (state != IDLE) && (state_nx == IDLE);
         bus.in_ready <= (state_nx == IDLE);
         if (accept)
            sync_idx <= 2'd0;
         else if (state == SYNC)
            sync_idx <= sync_idx + 2'd1;
         if (accept)
            bit_cnt <= '0;
         else if (take_data)
            bit_cnt <= bit_cnt + 1'b1;
      end
   end

   // Payload shift register: loaded on acceptance, shifted per data bit.
   always_ff @(posedge clk) begin
      if (accept)
         shreg <= bus.in_data;
      else if (take_data)
         shreg <= {shreg[DATA_W-2:0], 1'b0};
   end

`ifdef SEQ1001_TX_PARITY_EN
   // Even parity of the payload, captured together with the payload.
   always_ff @(posedge clk) begin
      if (accept)
         par_bit <= ^bus.in_data;
   end

   // Marks that the parity bit has gone out in the current frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         par_sent <= 1'b0;
      else if (accept)
         par_sent <= 1'b0;
      else if (state_nx == PARITY)
         par_sent <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_seq1001_tx.sv
// tb_seq1001_tx: bench for seq1001_tx (build with or without SEQ1001_TX_PARITY_EN).
module tb_seq1001_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sdo, busy, frame_done;

   seq1001_tx_if #(.DATA_W(8)) bus ();

   seq1001_tx #(.DATA_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .sdo        (sdo),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   bit got_q[$];
   bit exp_q[$];

   // Independent 1001 detector watching the whole line, idle included.
   logic [3:0] win = 4'hF;
   int det_cnt = 0;
   int det_pos = -1;
   int pos = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         win = 4'hF;
         pos = 0;
      end else begin
         win = {win[2:0], sdo};
         if (win == 4'b1001) begin
            det_cnt = det_cnt + 1;
            det_pos = busy ? pos : -1;
         end
         if (busy) pos = pos + 1;
         else pos = 0;
      end
   end

   // Expected frame from the link rules: sync, payload with zero stuffing,
   // optional parity (also stuffed).
   task automatic build_expected(input logic [7:0] d);
      int run;
      bit b;
      bit bits[$];
      exp_q.delete();
      exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
      for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
`ifdef SEQ1001_TX_PARITY_EN
      bits.push_back(^d);
`endif
      run = 0;
      foreach (bits[k]) begin
         b = bits[k];
         exp_q.push_back(b);
         run = b ? 0 : run + 1;
         if (run == 2) begin
            exp_q.push_back(0);
            run = 0;
         end
      end
   endtask

   // Expected frame from a literal bit string.
   task automatic expect_str(input string s);
      exp_q.delete();
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == "1");
`ifdef SEQ1001_TX_PARITY_EN
      exp_q.push_back(0);
`endif
   endtask

   function automatic string q2s(input bit q[$]);
      string s = "";
      foreach (q[i]) s = {s, q[i] ? "1" : "0"};
      return s;
   endfunction

   // Offer a payload, wait for acceptance; returns at the negedge after it.
   task automatic send(input logic [7:0] d, output int ok);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = (n < 100);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask

   // Sample sdo every cycle while busy; stops on a cycle budget.
   task automatic collect(output int ok);
      got_q.delete();
      ok = 1;
      while (busy === 1'b1) begin
         got_q.push_back(sdo);
         @(negedge clk);
         if (got_q.size() > 64) begin
            ok = 0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA5;
      repeat (3) @(negedge clk);
      tests++;
      if (sdo !== 1'b1 || bus.in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: sdo=%b in_ready=%b busy=%b frame_done=%b, need 1 1 0 0",
                  sdo, bus.in_ready, busy, frame_done);
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (busy !== 1'b0 || sdo !== 1'b1) begin
         fails++;
         $display("FAIL reset_no_accept: busy=%b sdo=%b, need 0 1", busy, sdo);
      end
   endtask

   // Sends one payload and checks its bits, frame_done pulse and idle line.
   task automatic run_frame(input logic [7:0] d, input string name);
      int ok, ok2, d0;
      d0 = det_cnt;
      send(d, ok);
      collect(ok2);
      tests++;
      if (!ok || !ok2 || got_q != exp_q) begin
         fails++;
         $display("FAIL %s_bits: got %s, need %s", name, q2s(got_q), q2s(exp_q));
      end
      tests++;
      if (frame_done !== 1'b1 || sdo !== 1'b1 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s_end: frame_done=%b sdo=%b in_ready=%b, need 1 1 1",
                  name, frame_done, sdo, bus.in_ready);
      end
      @(negedge clk);
      tests++;
      if (frame_done !== 1'b0 || sdo !== 1'b1) begin
         fails++;
         $display("FAIL %s_pulse: frame_done=%b sdo=%b, need 0 1", name, frame_done, sdo);
      end
      tests++;
      if (det_cnt - d0 != 1 || det_pos != 3) begin
         fails++;
         $display("FAIL %s_detect: count %0d at pos %0d, need 1 at 3", name, det_cnt - d0, det_pos);
      end
   endtask

   task automatic test_a5;
      expect_str("1001101000101");
      run_frame(8'hA5, "a5");
      tests++;
      if (got_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL a5_len: busy %0d cycles, need %0d", got_q.size(), exp_q.size());
      end
   endtask

   task automatic test_zeros;
      expect_str("1001000000000000");
      run_frame(8'h00, "zeros");
   endtask

   task automatic test_back_to_back;
      int ok, ok2;
      bit first[$];
      expect_str("100111111111");
      send(8'hFF, ok);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      collect(ok2);
      first = got_q;
      tests++;
      if (!ok || !ok2 || first != exp_q) begin
         fails++;
         $display("FAIL b2b_first: got %s, need %s", q2s(first), q2s(exp_q));
      end
      tests++;
      if (frame_done !== 1'b1 || sdo !== 1'b1 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_gap: frame_done=%b sdo=%b in_ready=%b, need 1 1 1",
                  frame_done, sdo, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      tests++;
      if (busy !== 1'b1 || sdo !== 1'b1) begin
         fails++;
         $display("FAIL b2b_second_start: busy=%b sdo=%b, need 1 1", busy, sdo);
      end
      collect(ok2);
      tests++;
      if (!ok2 || got_q != exp_q) begin
         fails++;
         $display("FAIL b2b_second: got %s, need %s", q2s(got_q), q2s(exp_q));
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int ok, seen;
      send(8'h3C, ok);
      repeat (7) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if (sdo !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b1 || frame_done !== 1'b0) begin
         fails++;
         $display("FAIL midreset_async: sdo=%b busy=%b in_ready=%b frame_done=%b, need 1 0 1 0",
                  sdo, busy, bus.in_ready, frame_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (frame_done === 1'b1 || busy === 1'b1) seen = 1;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL midreset_quiet: frame_done/busy seen=%0d, need 0", seen);
      end
      build_expected(8'h3C);
      run_frame(8'h3C, "after_reset");
   endtask

`ifdef SEQ1001_TX_PARITY_EN
   task automatic test_parity;
      exp_q.delete();
      begin
         string s = "1001100000000000110";
         for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == "1");
      end
      exp_q.delete();
      begin
         string s = "1001100000000010";
         for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == "1");
      end
      run_frame(8'h81, "parity81");
   endtask
`endif

   task automatic test_random;
      int ok, ok2, d0, bad;
      logic [7:0] d;
      bad = 0;
      for (int f = 0; f < 500; f++) begin
         d = 8'($urandom);
         build_expected(d);
         d0 = det_cnt;
         send(d, ok);
         collect(ok2);
         tests++;
         if (!ok || !ok2 || got_q != exp_q) begin
            fails++;
            if (bad < 5)
               $display("FAIL rand_bits d=%02h: got %s, need %s", d, q2s(got_q), q2s(exp_q));
            bad++;
         end
         tests++;
         if (det_cnt - d0 != 1 || det_pos != 3) begin
            fails++;
            if (bad < 5)
               $display("FAIL rand_detect d=%02h: count %0d at pos %0d, need 1 at 3",
                        d, det_cnt - d0, det_pos);
            bad++;
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset();
      test_a5();
      test_zeros();
      test_back_to_back();
      test_reset_mid();
`ifdef SEQ1001_TX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, need completion");
      $fatal(1, "watchdog");
   end

endmodule
